mips_mc_controller: RTL and testbench
=====================================

// Module: mips_mc_controller
// PURPOSE
//  Multicycle MIPS control FSM; the producer side of the ALU's 3-bit function-select.
//  Sequences fetch/decode/execute/memory/writeback for lw, sw, R-type, beq, addi, j.
//  Drives datapath muxes, enables and alu_sel. Inserts wait states on mem_ready.
//  Counts retired instructions.
// PARAMETERS
//  CNT_W  32  width of instr_count; wraps modulo 2^CNT_W
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  opcode       in   6      instr[31:26] from IR; stable from DECODE until next FETCH
//  funct        in   6      instr[5:0] from IR
//  zero         in   1      ALU zero flag
//  mem_ready    in   1      memory access completes this cycle
//  iord         out  1      0: mem addr = PC; 1: mem addr = ALUOut
//  mem_write    out  1      memory write strobe
//  ir_write     out  1      load IR
//  reg_dst      out  1      0: rt; 1: rd
//  mem_to_reg   out  1      0: ALUOut; 1: MDR
//  reg_write    out  1      register-file write enable
//  alu_src_a    out  1      0: PC; 1: rs (A)
//  alu_src_b    out  2      00: B; 01: const 4; 10: signext imm; 11: signext imm<<2
//  pc_src       out  2      00: ALU result; 01: ALUOut; 10: jump target
//  alu_sel      out  3      000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT
//  pc_en        out  1      pc_write | (branch & zero)
//  illegal      out  1      one-cycle pulse on an unsupported opcode or funct
//  instr_count  out  CNT_W  retired-instruction count
//  state_o      out  4      current state, for debug
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=FETCH, instr_count=0, illegal=0.
//    While rst_n=0, all enables (ir_write, pc_en, mem_write, reg_write) are forced to 0.
//  - Moore outputs decoded from state. Exceptions: pc_en uses zero, and ir_write/pc_en in FETCH
//    are gated by mem_ready. Unlisted outputs are 0.
//  - FETCH: alu_src_b=01, ADD, pc_src=00. If mem_ready: ir_write=1, pc_write=1, go to DECODE;
//    otherwise hold in FETCH.
//  - DECODE: alu_src_b=11, ADD (branch target precompute). Next state by opcode:
//    100011 or 101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX;
//    000010 -> JEX; any other -> FETCH with illegal=1.
//  - MEMADR: alu_src_a=1, alu_src_b=10, ADD. lw -> MEMRD; sw -> MEMWR.
//  - MEMRD: iord=1. Hold until mem_ready, then go to MEMWB.
//  - MEMWB: mem_to_reg=1, reg_write=1, then FETCH.
//  - MEMWR: iord=1, mem_write=1. Hold (strobe asserted) until mem_ready, then FETCH.
//  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_sel from funct:
//    100000->010, 100010->100, 100100->000, 100101->001, 101010->110, 011000->101.
//    Unknown funct -> illegal=1, go to FETCH, no writeback.
//  - RTYPEWB: reg_dst=1, reg_write=1, then FETCH.
//  - BEQEX: alu_src_a=1, SUB, pc_src=01, branch=1, then FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=10, ADD, then ADDIWB.
//  - ADDIWB: reg_write=1, then FETCH.
//  - JEX: pc_src=10, pc_write=1, then FETCH.
//  - Latency with no waits: lw 5 cycles; sw, R-type, addi 4; beq, j 3.
//  - instr_count += 1 on the transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB or JEX.
//    Not incremented on illegal. Wraps at 2^CNT_W-1 -> 0.
//  - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
//  - Reset asserted mid-operation: immediate return to FETCH. Any pending strobe drops the same cycle.
// STRUCTURE
//  - mips_pkg: opcode and funct constants, ALU_AND/OR/ADD/SUB/MUL/SLT 3-bit codes, state encodings.
//  - One sub-module: mips_alu_decoder (combinational funct -> alu_sel plus funct_illegal).
//  - State register and instr_count are the only flops.
// TESTING
//  - lw, mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 in cycle 5 with
//    mem_to_reg=1; instr_count 0->1.
//  - sw, mem_ready low 3 cycles in MEMWR: mem_write held 4 cycles with iord=1; then FETCH.
//  - R-type with funct 100010/101010/011000: alu_sel 100/110/101 in RTYPEEX; funct 111111:
//    illegal pulse, no reg_write.
//  - beq: zero=1 gives pc_en=1 with pc_src=01; zero=0 gives pc_en=0; both retire.
//  - opcode 111111: illegal=1 in DECODE, next state FETCH, instr_count unchanged.
//  - rst_n low mid-MEMWR: mem_write=0 at once, state_o=FETCH; CNT_W=4 wraps 15->0 after 16 j instructions.

Source files
------------

// File: rtl/mips_mc_controller_pkg.sv
// Shared constants and types for the multicycle MIPS controller:
// opcode/funct codes, ALU select codes, state encoding and the control word.
package mips_mc_controller_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b100;
  localparam logic [ALU_W-1:0] ALU_MUL = 3'b101;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b110;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  // Datapath control word decoded from the current state.
  typedef struct packed {
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [ALU_W-1:0] alu_sel;
    logic             pc_write;
    logic             branch;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath signal bundle; master is the datapath side, slave the controller.
interface mips_mc_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             iord;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_src;
  logic [2:0]       alu_sel;
  logic             pc_en;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state_o;

  modport master (
    output opcode, funct, zero, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, pc_src, alu_sel, pc_en, illegal, instr_count, state_o
  );

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, pc_src, alu_sel, pc_en, illegal, instr_count, state_o
  );
endinterface

// File: rtl/mips_mc_controller_alu_decoder.sv
// Combinational R-type funct -> ALU select decode with unsupported-funct flag.
module mips_mc_controller_alu_decoder
  import mips_mc_controller_pkg::*;
(
  input  logic [5:0]       funct_i,
  output logic [ALU_W-1:0] alu_sel_o,
  output logic             funct_illegal_o
);

  always_comb begin
    alu_sel_o       = ALU_AND;
    funct_illegal_o = 1'b0;
    case (funct_i)
      FN_ADD:  alu_sel_o = ALU_ADD;
      FN_SUB:  alu_sel_o = ALU_SUB;
      FN_AND:  alu_sel_o = ALU_AND;
      FN_OR:   alu_sel_o = ALU_OR;
      FN_SLT:  alu_sel_o = ALU_SLT;
      FN_MUL:  alu_sel_o = ALU_MUL;
      default: funct_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences lw/sw/R-type/beq/addi/j, drives the
// datapath controls and counts retired instructions.
module mips_mc_controller
  import mips_mc_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_mc_controller_if.slave   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_c;
  logic             retire_c;
  logic             illegal_c;
  logic [ALU_W-1:0] dec_sel;
  logic             dec_illegal;

  mips_mc_controller_alu_decoder u_alu_dec (
    .funct_i         (bus.funct),
    .alu_sel_o       (dec_sel),
    .funct_illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Moore control word; retire_c marks a completed instruction.
  always_comb begin
    state_d   = state_q;
    ctrl_c    = '0;
    retire_c  = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.alu_src_b = 2'b01;
        ctrl_c.alu_sel   = ALU_ADD;
        if (bus.mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = 2'b11;
        ctrl_c.alu_sel   = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = 2'b10;
        ctrl_c.alu_sel   = ALU_ADD;
        state_d          = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl_c.iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        state_d           = S_FETCH;
        retire_c          = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.iord      = 1'b1;
        ctrl_c.mem_write = 1'b1;
        if (bus.mem_ready) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_RTYPEEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_sel   = dec_sel;
        if (dec_illegal) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_RTYPEWB;
        end
      end
      S_RTYPEWB: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        state_d          = S_FETCH;
        retire_c         = 1'b1;
      end
      S_BEQEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_sel   = ALU_SUB;
        ctrl_c.pc_src    = 2'b01;
        ctrl_c.branch    = 1'b1;
        state_d          = S_FETCH;
        retire_c         = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = 2'b10;
        ctrl_c.alu_sel   = ALU_ADD;
        state_d          = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl_c.reg_write = 1'b1;
        state_d          = S_FETCH;
        retire_c         = 1'b1;
      end
      S_JEX: begin
        ctrl_c.pc_src   = 2'b10;
        ctrl_c.pc_write = 1'b1;
        state_d         = S_FETCH;
        retire_c        = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (retire_c) cnt_d = cnt_q + CNT_W'(1);
  end

  // Enables are qualified by rst_n so strobes drop the moment reset asserts.
  assign bus.iord        = ctrl_c.iord;
  assign bus.mem_write   = ctrl_c.mem_write & rst_n;
  assign bus.ir_write    = ctrl_c.ir_write & rst_n;
  assign bus.reg_write   = ctrl_c.reg_write & rst_n;
  assign bus.pc_en       = (ctrl_c.pc_write | (ctrl_c.branch & bus.zero)) & rst_n;
  assign bus.reg_dst     = ctrl_c.reg_dst;
  assign bus.mem_to_reg  = ctrl_c.mem_to_reg;
  assign bus.alu_src_a   = ctrl_c.alu_src_a;
  assign bus.alu_src_b   = ctrl_c.alu_src_b;
  assign bus.pc_src      = ctrl_c.pc_src;
  assign bus.alu_sel     = ctrl_c.alu_sel;
  assign bus.illegal     = illegal_c & rst_n;
  assign bus.instr_count = cnt_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: per-instruction expected cycle
// sequences, driven for a 32-bit and a 4-bit counter instance in lockstep.
module tb_mips_mc_controller;
  import mips_mc_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_mc_controller_if #(.CNT_W(32)) b32 ();
  mips_mc_controller_if #(.CNT_W(4))  b4 ();

  assign b4.opcode    = b32.opcode;
  assign b4.funct     = b32.funct;
  assign b4.zero      = b32.zero;
  assign b4.mem_ready = b32.mem_ready;

  mips_mc_controller #(.CNT_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  mips_mc_controller #(.CNT_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  // One expected cycle: inputs to apply and outputs required while they are applied.
  typedef struct {
    logic       mr, zr;
    logic [3:0] st;
    logic       irw, pce, mw, rw, iord, ill, m2r, ret;
    logic [2:0] alu;
    logic [1:0] pcs;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned exp_cnt  = 0;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_BAD = 6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Spec funct table: bit 3 = supported, bits 2:0 = ALU select.
  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1100;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1110;
      6'b011000: return 4'b1101;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e = '{default: '0};
    e.st = st;
    e.mr = 1'($urandom);
    e.zr = 1'($urandom);
    return e;
  endfunction

  // Expand one instruction into its expected cycle sequence.
  task automatic build(input int kind, input logic [5:0] fn, input int fw, input int mw,
                       input logic zb);
    exp_t e;
    logic [5:0] op;
    logic [3:0] ra;
    case (kind)
      K_LW:    op = 6'b100011;
      K_SW:    op = 6'b101011;
      K_R:     op = 6'b000000;
      K_BEQ:   op = 6'b000100;
      K_ADDI:  op = 6'b001000;
      K_J:     op = 6'b000010;
      default: begin
        op = 6'b111111;
        if (fw == 1) op = 6'b000001;
        if (fw == 2) op = 6'b001101;
      end
    endcase
    b32.opcode = op;
    b32.funct  = fn;
    for (int i = 0; i < fw; i++) begin
      e = mk(S_FETCH); e.mr = 1'b0; e.alu = 3'b010; q.push_back(e);
    end
    e = mk(S_FETCH); e.mr = 1'b1; e.alu = 3'b010; e.irw = 1'b1; e.pce = 1'b1; q.push_back(e);
    e = mk(S_DECODE); e.alu = 3'b010; e.ill = (kind == K_BAD); q.push_back(e);
    case (kind)
      K_LW, K_SW: begin
        e = mk(S_MEMADR); e.alu = 3'b010; q.push_back(e);
        for (int i = 0; i <= mw; i++) begin
          e = mk(kind == K_LW ? S_MEMRD : S_MEMWR);
          e.mr = (i == mw); e.iord = 1'b1; e.mw = (kind == K_SW);
          e.ret = (kind == K_SW) && (i == mw);
          q.push_back(e);
        end
        if (kind == K_LW) begin
          e = mk(S_MEMWB); e.m2r = 1'b1; e.rw = 1'b1; e.ret = 1'b1; q.push_back(e);
        end
      end
      K_R: begin
        ra = ref_alu(fn);
        e = mk(S_RTYPEEX); e.alu = ra[2:0]; e.ill = ~ra[3]; q.push_back(e);
        if (ra[3]) begin
          e = mk(S_RTYPEWB); e.rw = 1'b1; e.ret = 1'b1; q.push_back(e);
        end
      end
      K_BEQ: begin
        e = mk(S_BEQEX); e.zr = zb; e.alu = 3'b100; e.pcs = 2'b01; e.pce = zb; e.ret = 1'b1;
        q.push_back(e);
      end
      K_ADDI: begin
        e = mk(S_ADDIEX); e.alu = 3'b010; q.push_back(e);
        e = mk(S_ADDIWB); e.rw = 1'b1; e.ret = 1'b1; q.push_back(e);
      end
      K_J: begin
        e = mk(S_JEX); e.pcs = 2'b10; e.pce = 1'b1; e.ret = 1'b1; q.push_back(e);
      end
      default: ;
    endcase
  endtask

  // Apply n queued cycles (all when n < 0); entered and left at posedge+1.
  task automatic run_q(input int n);
    exp_t e;
    int   k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      e = q.pop_front();
      k++;
      b32.mem_ready = e.mr;
      b32.zero      = e.zr;
      #4;
      chk("state",     32'(b32.state_o),    32'(e.st));
      chk("ir_write",  32'(b32.ir_write),   32'(e.irw));
      chk("pc_en",     32'(b32.pc_en),      32'(e.pce));
      chk("mem_write", 32'(b32.mem_write),  32'(e.mw));
      chk("reg_write", 32'(b32.reg_write),  32'(e.rw));
      chk("iord",      32'(b32.iord),       32'(e.iord));
      chk("illegal",   32'(b32.illegal),    32'(e.ill));
      chk("mem_to_reg",32'(b32.mem_to_reg), 32'(e.m2r));
      chk("alu_sel",   32'(b32.alu_sel),    32'(e.alu));
      chk("pc_src",    32'(b32.pc_src),     32'(e.pcs));
      chk("count32",   b32.instr_count,     exp_cnt);
      chk("count4",    32'(b4.instr_count), 32'(exp_cnt % 16));
      @(posedge clk);
      #1;
      if (e.ret) exp_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b32.mem_ready = 1'b1;
    b32.zero = 1'b1;
    b32.opcode = 6'b000000;
    b32.funct = 6'b000000;
    #2;
    chk("rst_state",    32'(b32.state_o),    32'(S_FETCH));
    chk("rst_ir_write", 32'(b32.ir_write),   32'd0);
    chk("rst_pc_en",    32'(b32.pc_en),      32'd0);
    chk("rst_count",    b32.instr_count,     32'd0);
    chk("rst_illegal",  32'(b32.illegal),    32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  initial begin
    logic [5:0] good_fn [6];
    logic [5:0] fn;
    int kind;
    good_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};

    do_reset();

    // Directed scenarios.
    build(K_LW, 6'h15, 0, 0, 1'b0);         run_q(-1);
    build(K_SW, 6'h15, 0, 3, 1'b0);         run_q(-1);
    build(K_R, 6'b100010, 0, 0, 1'b0);      run_q(-1);
    build(K_R, 6'b101010, 1, 0, 1'b0);      run_q(-1);
    build(K_R, 6'b011000, 0, 0, 1'b0);      run_q(-1);
    build(K_R, 6'b111111, 0, 0, 1'b0);      run_q(-1);
    build(K_BEQ, 6'h00, 0, 0, 1'b1);        run_q(-1);
    build(K_BEQ, 6'h00, 0, 0, 1'b0);        run_q(-1);
    build(K_BAD, 6'h00, 0, 0, 1'b0);        run_q(-1);
    build(K_ADDI, 6'h00, 2, 0, 1'b0);       run_q(-1);
    build(K_J, 6'h00, 0, 0, 1'b0);          run_q(-1);

    // Random instruction stream with random wait states.
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 6));
      fn = 6'($urandom);
      if (kind == K_R && $urandom_range(0, 3) != 0) fn = good_fn[$urandom_range(0, 5)];
      build(kind, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
      run_q(-1);
    end

    // Reset in the middle of a stalled store.
    build(K_SW, 6'h00, 0, 5, 1'b0);
    run_q(4);
    b32.mem_ready = 1'b0;
    #2;
    chk("memwr_before_rst", 32'(b32.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("memwr_after_rst",  32'(b32.mem_write), 32'd0);
    chk("state_after_rst",  32'(b32.state_o),   32'(S_FETCH));
    chk("count_after_rst",  b32.instr_count,    32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      build(K_J, 6'h00, 0, 0, 1'b0);
      run_q(-1);
    end
    chk("wrap4",  32'(b4.instr_count), 32'd0);
    chk("count16", b32.instr_count,    32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
